cache_line_mover: RTL and testbench
===================================

// Module: cache_line_mover
// PURPOSE
//  Line writeback/refill engine directly downstream of the cache control FSM: on EVICT it writes the dirty
//  victim line to main memory beat by beat, then reads the missing line and returns it for install.
//  Sits between the cache control FSM and the main-memory bus; one transaction outstanding at a time.
// PARAMETERS
//  PA_WIDTH   32   physical address width
//  BLK_SIZE   128  cache line width in bits
//  MEM_WIDTH  32   memory data bus width in bits; BLK_SIZE % MEM_WIDTH == 0
//  BO_WIDTH   4    byte-offset bits of a line (log2(BLK_SIZE/8))
//  TMO_CYCLES 255  per-beat ack timeout (only with CACHE_MEM_TIMEOUT_EN)
// PORTS
//  clk        in  1          clock, all logic on posedge
//  rst        in  1          synchronous active-high reset
//  req_valid  in  1          transaction request from control FSM
//  req_ready  out 1          engine idle, request accepted when req_valid&&req_ready
//  req_wb     in  1          victim dirty: perform writeback before refill
//  wb_addr    in  PA_WIDTH   victim line address (offset bits ignored)
//  wb_data    in  BLK_SIZE   victim line data
//  fill_addr  in  PA_WIDTH   missing line address (offset bits ignored)
//  fill_data  out BLK_SIZE   refilled line, valid when done=1
//  done       out 1          one-cycle pulse: transaction complete
//  err        out 1          one-cycle pulse with done on timeout abort (0 if timeout compiled out)
//  mem_rd_en  out 1          memory read beat request
//  mem_wr_en  out 1          memory write beat request
//  mem_addr   out PA_WIDTH   beat address, MEM_WIDTH/8 aligned
//  mem_wdata  out MEM_WIDTH  write beat data
//  mem_rdata  in  MEM_WIDTH  read beat data, sampled when mem_ack=1
//  mem_ack    in  1          memory completes current beat this cycle
// BEHAVIOUR
//  - Reset: state=IDLE, req_ready=1, done=0, err=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0,
//    fill_data=0, beat counter=0. Reset mid-transaction aborts immediately; no done pulse.
//  - States: IDLE -> (req_wb ? WB : FILL) on accept; WB -> FILL after last write beat acked;
//    FILL -> DONE after last read beat acked; DONE -> IDLE (done=1 for exactly this cycle).
//  - Request latched on accept (addresses, wb_data, req_wb); inputs ignored until back in IDLE.
//  - NBEATS = BLK_SIZE/MEM_WIDTH; beat counter 0..NBEATS-1, wraps to 0 on leaving WB/FILL.
//  - Beat k: mem_addr = {line_addr[PA_WIDTH-1:BO_WIDTH], BO_WIDTH'(k*MEM_WIDTH/8)};
//    mem_wdata = wb_data[k*MEM_WIDTH +: MEM_WIDTH]; read data stored into fill_data[k*MEM_WIDTH +: MEM_WIDTH].
//  - mem_rd_en/mem_wr_en held high from first cycle of the state until ack of the last beat; never both
//    high; address/data stable while waiting; advances one beat per ack (back-to-back acks allowed).
//  - mem_ack while neither enable high is ignored. req_valid while busy: req_ready=0, no effect.
//  - Min latency from accept to done: NBEATS+1 cycles (no wb), 2*NBEATS+1 (wb), with ack every cycle.
//  - fill_data holds its value until the next transaction's first read ack.
// CONFIGURATION
//  CACHE_MEM_TIMEOUT_EN defined: 8-bit counter cleared on each ack/state entry; reaching TMO_CYCLES in WB or
//  FILL drops enables, goes to DONE, pulses done and err together; fill_data contents then undefined.
//  Not defined: no counter, waits indefinitely for mem_ack; err tied 0.
// STRUCTURE
//  Shared package/macros.v: state encodings (IDLE/WB/FILL/DONE), NBEATS, beat address alignment macro.
//  Single module; no sub-module required (beat counter + FSM inline).
// TESTING
//  1) Clean miss: req_wb=0, fill_addr=0x1000_0004, ack every cycle -> read addrs 0x1000_0000..0C, done at cycle 5.
//  2) Dirty miss: wb_addr=0x2000_0010, wb_data=0x44..33..22..11 -> 4 writes 0x2000_0010..1C with words 11,22,33,44, then 4 reads, done.
//  3) Ack stalls: ack only every 3rd cycle -> enables/addr/wdata stable across stall, fill_data correct.
//  4) Busy request: req_valid pulsed mid-FILL -> req_ready=0, ignored, single done.
//  5) Reset mid-WB (after beat 2) -> all outputs at reset values next cycle, no done; next request runs clean.
//  6) CACHE_MEM_TIMEOUT_EN, no ack -> done=err=1 after TMO_CYCLES, enables low, back to IDLE.

Source files
------------

// File: rtl/cache_line_mover_pkg.sv
// cache_line_mover_pkg
//   Shared definitions for the cache line writeback/refill engine:
//   - state_t      : FSM encoding (IDLE / WB / FILL / DONE)
//   - DEF_*        : default geometry used as parameter defaults by the engine
//   - beat_byte_offset() : byte offset of beat k inside a line, used to build
//                          the MEM_WIDTH/8-aligned beat address
package cache_line_mover_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DEF_PA_WIDTH   = 32;
    localparam int DEF_BLK_SIZE   = 128;
    localparam int DEF_MEM_WIDTH  = 32;
    localparam int DEF_BO_WIDTH   = 4;
    localparam int DEF_TMO_CYCLES = 255;

    // Byte offset of beat 'beat' within a line for a bus of 'mem_width' bits.
    function automatic int beat_byte_offset(input int beat, input int mem_width);
        return beat * (mem_width / 8);
    endfunction

endpackage

// File: rtl/cache_line_mover.sv
// cache_line_mover
//   Line writeback/refill engine between the cache control FSM and the
//   main-memory bus. On an accepted request it optionally writes the dirty
//   victim line out beat by beat (WB), then reads the missing line beat by
//   beat (FILL), and pulses done for one cycle with the refilled line on
//   fill_data. One transaction outstanding at a time.
//
//   Optional feature macro: CACHE_MEM_TIMEOUT_EN
//     defined   : an 8-bit per-beat ack timeout aborts WB/FILL after
//                 TMO_CYCLES cycles without mem_ack; done and err pulse together.
//     undefined : waits indefinitely for mem_ack; err is tied low.
//
//   Ports
//     clk, rst              clock (posedge) and synchronous active-high reset
//     req_valid/req_ready   request handshake from the control FSM
//     req_wb                victim is dirty: write it back before the refill
//     wb_addr, wb_data      victim line address (offset bits ignored) and data
//     fill_addr             missing line address (offset bits ignored)
//     fill_data             refilled line, valid while done=1, held afterwards
//     done, err             completion pulse; err marks a timeout abort
//     mem_rd_en, mem_wr_en  read / write beat request (never both high)
//     mem_addr, mem_wdata   beat address (MEM_WIDTH/8 aligned) and write data
//     mem_rdata, mem_ack    read data and beat completion from memory
//
//   Handshake: a request transfers on a cycle where req_valid && req_ready;
//   req_ready is high only in IDLE, so req_valid while busy has no effect.
//   A memory beat completes on a cycle where mem_ack is high while its enable
//   is high; the enable, address and data hold until that cycle. mem_ack with
//   no enable high is ignored.
module cache_line_mover
    import cache_line_mover_pkg::*;
#(
    parameter int PA_WIDTH   = DEF_PA_WIDTH,
    parameter int BLK_SIZE   = DEF_BLK_SIZE,
    parameter int MEM_WIDTH  = DEF_MEM_WIDTH,
    parameter int BO_WIDTH   = DEF_BO_WIDTH,
    parameter int TMO_CYCLES = DEF_TMO_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wb,
    input  logic [PA_WIDTH-1:0]  wb_addr,
    input  logic [BLK_SIZE-1:0]  wb_data,
    input  logic [PA_WIDTH-1:0]  fill_addr,
    output logic [BLK_SIZE-1:0]  fill_data,
    output logic                 done,
    output logic                 err,
    output logic                 mem_rd_en,
    output logic                 mem_wr_en,
    output logic [PA_WIDTH-1:0]  mem_addr,
    output logic [MEM_WIDTH-1:0] mem_wdata,
    input  logic [MEM_WIDTH-1:0] mem_rdata,
    input  logic                 mem_ack
);

    localparam int NBEATS = BLK_SIZE / MEM_WIDTH;
    localparam int BCW    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int LAW    = PA_WIDTH - BO_WIDTH;

    state_t               state_q, state_d;
    logic [BCW-1:0]       beat_q, beat_d;
    logic [LAW-1:0]       wb_line_q, fill_line_q;
    logic [BLK_SIZE-1:0]  wb_data_q;
    logic [BLK_SIZE-1:0]  fill_data_q;

    logic                 busy;
    logic                 last_beat;
    logic [LAW-1:0]       line_addr;
    logic [BO_WIDTH-1:0]  beat_off;
    logic                 tmo_hit;

    // Offset bits of the request addresses are not needed: beats are
    // addressed from the line base.
    logic [2*BO_WIDTH-1:0] unused_offset_bits;
    assign unused_offset_bits = {wb_addr[BO_WIDTH-1:0], fill_addr[BO_WIDTH-1:0]};

    assign busy      = (state_q == ST_WB) || (state_q == ST_FILL);
    assign last_beat = (beat_q == BCW'(NBEATS - 1));
    assign line_addr = (state_q == ST_WB) ? wb_line_q : fill_line_q;
    assign beat_off  = BO_WIDTH'(beat_byte_offset(int'(beat_q), MEM_WIDTH));

    assign req_ready = (state_q == ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign mem_wr_en = (state_q == ST_WB);
    assign mem_rd_en = (state_q == ST_FILL);
    assign mem_addr  = busy ? {line_addr, beat_off} : '0;
    assign mem_wdata = (state_q == ST_WB) ? wb_data_q[beat_q*MEM_WIDTH +: MEM_WIDTH] : '0;
    assign fill_data = fill_data_q;

`ifdef CACHE_MEM_TIMEOUT_EN
    logic [7:0] tmo_q;
    logic       err_q;

    // tmo_q counts cycles spent waiting for the current beat; the abort
    // fires on the TMO_CYCLES-th consecutive cycle without an ack.
    assign tmo_hit = busy && !mem_ack && (tmo_q == 8'(TMO_CYCLES - 1));
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            // tmo_hit always leads into DONE, so err_q is high exactly there.
            err_q <= tmo_hit;
            if (mem_ack || (state_d != state_q)) begin
                tmo_q <= '0;
            end else if (busy) begin
                tmo_q <= tmo_q + 8'd1;
            end
        end
    end
`else
    logic [7:0] unused_tmo_cycles;
    assign unused_tmo_cycles = 8'(TMO_CYCLES);
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    // Next-state and beat counter.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: begin
                beat_d = '0;
                if (req_valid) begin
                    state_d = req_wb ? ST_WB : ST_FILL;
                end
            end
            ST_WB: begin
                if (mem_ack) begin
                    if (last_beat) begin
                        state_d = ST_FILL;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BCW'(1);
                    end
                end
            end
            ST_FILL: begin
                if (mem_ack) begin
                    if (last_beat) begin
                        state_d = ST_DONE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BCW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
        endcase
        if (tmo_hit) begin
            state_d = ST_DONE;
            beat_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            wb_line_q   <= '0;
            fill_line_q <= '0;
            wb_data_q   <= '0;
            fill_data_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if ((state_q == ST_IDLE) && req_valid) begin
                wb_line_q   <= wb_addr[PA_WIDTH-1:BO_WIDTH];
                fill_line_q <= fill_addr[PA_WIDTH-1:BO_WIDTH];
                wb_data_q   <= wb_data;
            end
            if ((state_q == ST_FILL) && mem_ack) begin
                fill_data_q[beat_q*MEM_WIDTH +: MEM_WIDTH] <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_cache_line_mover.sv
// tb_cache_line_mover
//   Directed bench for cache_line_mover. A memory responder process checks
//   every beat against expected write/read queues filled when a request is
//   driven, and returns address-derived read data; the main sequence checks
//   done latency, fill_data, err and reset behaviour.
module tb_cache_line_mover;

    localparam int PA  = 32;
    localparam int BLK = 128;
    localparam int MW  = 32;
    localparam int NB  = BLK / MW;
    localparam int TMO = 255;

    logic            clk;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic            req_wb;
    logic [PA-1:0]   wb_addr;
    logic [BLK-1:0]  wb_data;
    logic [PA-1:0]   fill_addr;
    logic [BLK-1:0]  fill_data;
    logic            done;
    logic            err;
    logic            mem_rd_en;
    logic            mem_wr_en;
    logic [PA-1:0]   mem_addr;
    logic [MW-1:0]   mem_wdata;
    logic [MW-1:0]   mem_rdata;
    logic            mem_ack;

    cache_line_mover #(
        .PA_WIDTH  (PA),
        .BLK_SIZE  (BLK),
        .MEM_WIDTH (MW),
        .BO_WIDTH  (4),
        .TMO_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wb    (req_wb),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .fill_addr (fill_addr),
        .fill_data (fill_data),
        .done      (done),
        .err       (err),
        .mem_rd_en (mem_rd_en),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Scoreboard queues: writes hold {addr, data}.
    logic [63:0]  exp_wr_q[$];
    logic [31:0]  exp_rd_q[$];
    logic [127:0] exp_fill_q[$];

    int ack_mode = 0;   // 0 every cycle (+stray acks when idle), 1 every 3rd, 2 never, 3 random
    int ack_div  = 0;
    int wr_acks  = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A5A_C3C3;
    endfunction

    // Memory responder: decides mem_ack at each negedge and checks the beat
    // presented against the head of the matching queue (also while stalled).
    initial begin
        logic give;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (!rst) begin
                give = 1'b0;
                if (mem_rd_en || mem_wr_en) begin
                    check("en_exclusive", {127'b0, mem_rd_en & mem_wr_en}, 128'd0);
                    case (ack_mode)
                        0: give = 1'b1;
                        1: give = (ack_div % 3 == 2);
                        2: give = 1'b0;
                        default: give = 1'($urandom_range(0, 1));
                    endcase
                    ack_div++;
                end
                if (mem_wr_en) begin
                    if (exp_wr_q.size() == 0) begin
                        check("wr_unexpected", 128'd1, 128'd0);
                    end else begin
                        check("wr_addr", {96'b0, mem_addr}, {96'b0, exp_wr_q[0][63:32]});
                        check("wr_data", {96'b0, mem_wdata}, {96'b0, exp_wr_q[0][31:0]});
                        if (give) begin
                            void'(exp_wr_q.pop_front());
                            wr_acks++;
                        end
                    end
                    mem_ack = give;
                end else if (mem_rd_en) begin
                    if (exp_rd_q.size() == 0) begin
                        check("rd_unexpected", 128'd1, 128'd0);
                    end else begin
                        check("rd_addr", {96'b0, mem_addr}, {96'b0, exp_rd_q[0]});
                        if (give) void'(exp_rd_q.pop_front());
                    end
                    mem_rdata = rd_word(mem_addr);
                    mem_ack   = give;
                end else begin
                    // Stray acks with no enable must be ignored by the DUT.
                    mem_ack   = (ack_mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                    mem_rdata = $urandom;
                end
            end
        end
    end

    // Driver: called at a negedge; accepts at the next posedge and pushes
    // the expected beats and refilled line.
    task automatic drive_req(input logic wb, input logic [31:0] waddr,
                             input logic [127:0] wdata, input logic [31:0] faddr);
        logic [127:0] fl;
        logic [31:0]  a;
        fl = '0;
        for (int k = 0; k < NB; k++) begin
            if (wb) begin
                a = {waddr[31:4], 4'(k * 4)};
                exp_wr_q.push_back({a, wdata[k*32 +: 32]});
            end
            a = {faddr[31:4], 4'(k * 4)};
            exp_rd_q.push_back(a);
            fl[k*32 +: 32] = rd_word(a);
        end
        exp_fill_q.push_back(fl);
        check("req_ready_idle", {127'b0, req_ready}, 128'd1);
        req_valid = 1'b1;
        req_wb    = wb;
        wb_addr   = waddr;
        wb_data   = wdata;
        fill_addr = faddr;
        @(posedge clk);
        #1;
        // Scramble inputs: the engine must work from its latched copy.
        req_valid = 1'b0;
        req_wb    = 1'($urandom_range(0, 1));
        wb_addr   = $urandom;
        wb_data   = {$urandom, $urandom, $urandom, $urandom};
        fill_addr = $urandom;
    endtask

    task automatic wait_done(input int limit, input logic exp_err, output int cycles);
        logic got;
        logic [127:0] ef;
        got    = 1'b0;
        cycles = 0;
        while (cycles < limit && !got) begin
            @(negedge clk);
            cycles++;
            if (done) got = 1'b1;
        end
        if (!got) begin
            check("done_timeout", 128'd0, 128'd1);
        end else begin
            check("err_at_done", {127'b0, err}, {127'b0, exp_err});
            check("en_low_at_done", {126'b0, mem_rd_en, mem_wr_en}, 128'd0);
            if (!exp_err) begin
                ef = (exp_fill_q.size() != 0) ? exp_fill_q.pop_front() : 128'hx;
                check("fill_data", fill_data, ef);
                check("beats_left", 128'(exp_wr_q.size() + exp_rd_q.size()), 128'd0);
            end else begin
                exp_wr_q.delete();
                exp_rd_q.delete();
                exp_fill_q.delete();
            end
        end
        @(negedge clk);
        check("done_single", {127'b0, done}, 128'd0);
        check("ready_after", {127'b0, req_ready}, 128'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {127'b0, req_ready}, 128'd1);
        check({tag, "_done_err"}, {126'b0, done, err}, 128'd0);
        check({tag, "_en"}, {126'b0, mem_rd_en, mem_wr_en}, 128'd0);
        check({tag, "_addr"}, {96'b0, mem_addr}, 128'd0);
        check({tag, "_wdata"}, {96'b0, mem_wdata}, 128'd0);
        check({tag, "_fill"}, fill_data, 128'd0);
    endtask

    initial begin
        int cyc;
        int guard;
        logic [127:0] line_fill;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_wb    = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        fill_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // 1) Clean miss, ack every cycle: done NBEATS+1 cycles after accept.
        ack_mode = 0;
        drive_req(1'b0, $urandom, {$urandom, $urandom, $urandom, $urandom}, 32'h1000_0004);
        wait_done(50, 1'b0, cyc);
        check("lat_clean", 128'(cyc), 128'd5);

        // 2) Dirty miss: four writes then four reads, 2*NBEATS+1 latency.
        drive_req(1'b1, 32'h2000_0010, 128'h00000044_00000033_00000022_00000011, 32'h3000_0020);
        wait_done(50, 1'b0, cyc);
        check("lat_dirty", 128'(cyc), 128'd9);

        // 3) Ack every third cycle: beats must stay stable while stalled.
        ack_mode = 1;
        ack_div  = 0;
        drive_req(1'b1, 32'h4000_0100, {$urandom, $urandom, $urandom, $urandom}, 32'h5000_0230);
        wait_done(200, 1'b0, cyc);
        check("lat_stall", 128'(cyc), 128'd25);

        // 4) Request pulsed mid-FILL is refused and has no effect.
        ack_div = 0;
        drive_req(1'b0, 32'h0, '0, 32'h6000_0040);
        repeat (3) @(negedge clk);
        check("busy_in_fill", {127'b0, mem_rd_en}, 128'd1);
        req_valid = 1'b1;
        req_wb    = 1'b1;
        wb_addr   = 32'h7000_0000;
        fill_addr = 32'h7100_0000;
        check("busy_not_ready", {127'b0, req_ready}, 128'd0);
        @(negedge clk);
        req_valid = 1'b0;
        wait_done(200, 1'b0, cyc);
        repeat (4) @(negedge clk);
        check("busy_no_second", {127'b0, done | mem_rd_en | mem_wr_en}, 128'd0);

        // 5) Reset during writeback after two beats: no done, reset outputs.
        ack_mode = 0;
        wr_acks  = 0;
        drive_req(1'b1, 32'h8000_0000, {$urandom, $urandom, $urandom, $urandom}, 32'h9000_0000);
        guard = 0;
        while (wr_acks < 2 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        check("rst_reached_beat2", 128'(wr_acks >= 2), 128'd1);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        exp_wr_q.delete();
        exp_rd_q.delete();
        exp_fill_q.delete();
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        @(negedge clk);
        check("midrst_no_done", {127'b0, done}, 128'd0);
        drive_req(1'b1, 32'hA000_0030, {$urandom, $urandom, $urandom, $urandom}, 32'hB000_0070);
        wait_done(50, 1'b0, cyc);
        check("lat_after_rst", 128'(cyc), 128'd9);

        // Random transactions with random ack timing.
        ack_mode = 3;
        for (int t = 0; t < 4; t++) begin
            drive_req(1'($urandom_range(0, 1)), $urandom,
                      {$urandom, $urandom, $urandom, $urandom}, $urandom);
            wait_done(2000, 1'b0, cyc);
        end
        line_fill = fill_data;
        repeat (3) @(negedge clk);
        check("fill_hold", fill_data, line_fill);

`ifdef CACHE_MEM_TIMEOUT_EN
        // 6) No ack at all: abort after TMO_CYCLES waiting cycles.
        ack_mode = 2;
        drive_req(1'b0, 32'h0, '0, 32'hC000_0000);
        wait_done(TMO + 20, 1'b1, cyc);
        check("lat_timeout", 128'(cyc), 128'(TMO + 1));
        ack_mode = 0;
        drive_req(1'b0, 32'h0, '0, 32'hD000_0010);
        wait_done(50, 1'b0, cyc);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
